// File: rtl/stream_demux_reg.sv
// -----------------------------------------------------------------------------
// stream_demux_reg
//   Registered 1-to-NUM_CH stream demultiplexer with valid/ready flow control.
//   Each accepted input word goes into a one-entry register on the channel
//   named by s_sel. The word appears on that channel one cycle after it is
//   accepted. If s_sel names a channel that does not exist, the word is still
//   accepted but is thrown away, and a saturating counter records the drop.
//
//   Optional feature macro: STREAM_DEMUX_BCAST_EN
//     When defined, the block gains an s_bcast input. While s_bcast is high,
//     s_sel is ignored and an accepted word loads every channel at once. The
//     input is ready only when every channel can take the word.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active high
//   s_valid   input word valid
//   s_ready   input accepted this cycle (combinational; never uses s_valid)
//   s_data    input word, DATA_W bits
//   s_sel     destination channel index, SEL_W bits
//   s_bcast   load all channels (only with STREAM_DEMUX_BCAST_EN)
//   m_valid   per-channel output valid (registered)
//   m_ready   per-channel consumer ready
//   m_data    channel k at bits [k*DATA_W +: DATA_W] (registered)
//   drop_cnt  count of out-of-range words; sticks at all-ones
//
// Parameters
//   DATA_W  word width
//   NUM_CH  number of channels, 2..64
//   SEL_W   select width; 2**SEL_W must be >= NUM_CH
//   CNT_W   drop counter width
// -----------------------------------------------------------------------------
module stream_demux_reg #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                     s_bcast,
`endif
  output logic [NUM_CH-1:0]        m_valid,
  input  logic [NUM_CH-1:0]        m_ready,
  output logic [NUM_CH*DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Add one to the drop counter, but stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic [NUM_CH-1:0] can_load;  // channel register can take a word this cycle
  logic [NUM_CH-1:0] hit;       // one-hot decode of s_sel, all zero when out of range
  logic [NUM_CH-1:0] load;      // channel register captures s_data at the next edge
  logic              sel_hit;
  logic              bcast;
  logic              drop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = s_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A slot is free when it is empty, or when its word drains in this same
  // cycle. Because of the same-cycle drain, one word per cycle is sustained.
  assign can_load = ~m_valid | m_ready;

  // Decode s_sel against the channels that actually exist.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit[k] = (s_sel == SEL_W'(k));
    end
  end

  assign sel_hit = |hit;

  // Work out the handshake, which channels load, and whether a word is dropped.
  // None of this depends on s_valid except load and drop themselves.
  always_comb begin
    s_ready = 1'b1;
    load    = '0;
    drop    = 1'b0;
    if (bcast) begin
      s_ready = &can_load;
      load    = {NUM_CH{s_valid & (&can_load)}};
    end else if (sel_hit) begin
      s_ready = |(hit & can_load);
      load    = hit & can_load & {NUM_CH{s_valid}};
    end else begin
      // Out-of-range words are always accepted and then thrown away.
      s_ready = 1'b1;
      drop    = s_valid;
    end
  end

  // Channel registers. A load takes priority; the old word counts as drained
  // if the consumer takes it in the same cycle. A drain with no load empties
  // the slot. m_data keeps its last value after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= '0;
      m_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          m_valid[k]                   <= 1'b1;
          m_data[k*DATA_W +: DATA_W]   <= s_data;
        end else if (m_ready[k]) begin
          m_valid[k]                   <= 1'b0;
        end else begin
          m_valid[k]                   <= m_valid[k];
        end
      end
    end
  end

  // Saturating count of dropped out-of-range words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
    end else begin
      drop_cnt <= drop_cnt;
    end
  end

endmodule
